wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
- Writer side of the register-file write-back path. It is the MEM/WB pipeline register plus write-back select.
- Captures retiring instructions from the MEM stage and waits on a variable-latency load-data handshake.
- Drives the single-cycle register-file write (WriteRegister/WriteData/RegWrite). The decode-stage write-back forwarding logic and the register file consume this write.
- Stalls the upstream pipeline while a load is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT_LOAD before abort (used only with the optional feature).
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents a retiring instruction
- in_ready  out  1  stage accepts; transfer occurs when in_valid && in_ready
- RegWrite_in  in  1  instruction writes a register
- MemtoReg_in  in  1  1 = load (data from LoadData), 0 = ALU result
- WriteRegister_in  in  5  destination register
- ALUResult_in  in  32  ALU result
- LoadData  in  32  data memory read data
- LoadValid  in  1  LoadData valid this cycle
- flush  in  1  synchronous squash
- WriteRegister  out  5  register-file write address
- WriteData  out  32  register-file write data
- RegWrite  out  1  register-file write enable, one-cycle pulse
- load_stall  out  1  high while a load is outstanding
- load_error  out  1  one-cycle pulse on load timeout (optional feature only)
- retired_count  out  CNT_W  number of committed instructions

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - RegWrite=0, WriteRegister=0, WriteData=0, retired_count=0, load_error=0.
  - load_stall=0, in_ready=1.
- States: IDLE, WAIT_LOAD.
- in_ready = (state==IDLE). load_stall = (state==WAIT_LOAD). Both are combinational from state only.
- IDLE, transfer with MemtoReg_in=0, at cycle N:
  - Cycle N+1: WriteRegister=WriteRegister_in, WriteData=ALUResult_in.
  - Cycle N+1: RegWrite = RegWrite_in && (WriteRegister_in!=0). Register $0 is never written.
  - Back-to-back transfers every cycle are supported, giving one commit per cycle.
- IDLE, transfer with MemtoReg_in=1, at cycle N:
  - Latch RegWrite_in and WriteRegister_in; enter WAIT_LOAD at N+1.
  - No commit at N+1; RegWrite=0.
- WAIT_LOAD:
  - LoadValid is sampled each cycle. LoadValid is ignored outside WAIT_LOAD, including the capture cycle.
  - On LoadValid=1 at cycle M: cycle M+1 commits with WriteData=LoadData(M) and the latched register; state=IDLE at M+1.
  - Minimum load latency from transfer to commit: 2 cycles.
- Commit rules:
  - Every commit increments retired_count by 1, whether or not RegWrite_in was set. The counter wraps modulo 2^CNT_W.
  - RegWrite is high for exactly one cycle per commit with a nonzero destination.
  - WriteRegister/WriteData hold their last values when RegWrite=0.
- flush=1 at cycle F:
  - Has priority over in_valid and LoadValid.
  - Any transfer or LoadValid in cycle F is discarded.
  - State=IDLE at F+1; RegWrite=0 at F+1; retired_count unchanged.
- rst_n asserted mid-WAIT_LOAD: immediate return to reset values; the pending load is lost.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle without LoadValid.
  - When it reaches TIMEOUT_CYCLES: load_error pulses 1 for one cycle, state=IDLE, no register write, retired_count unchanged.
  - LoadValid arriving in the expiry cycle wins, giving a normal commit with no error.
- Undefined:
  - No counter; WAIT_LOAD persists until LoadValid, flush or reset.
  - load_error is tied to 0.

Test Plan:
- ALU op, reset released, cycle N: in_valid=1, RegWrite_in=1, MemtoReg_in=0, WriteRegister_in=5, ALUResult_in=0x0000_00AA -> cycle N+1: RegWrite=1, WriteRegister=5, WriteData=0xAA, retired_count=1.
- Write to $0: WriteRegister_in=0, RegWrite_in=1, ALUResult_in=0x1234 -> RegWrite stays 0; retired_count increments.
- Load: transfer with MemtoReg_in=1, WriteRegister_in=9; LoadValid=1 with LoadData=0xDEADBEEF 3 cycles later:
  - in_ready=0 and load_stall=1 during the wait.
  - Next cycle: RegWrite=1, WriteRegister=9, WriteData=0xDEADBEEF; in_ready=1.
- Back-to-back: 4 consecutive ALU transfers to regs 1..4 -> 4 consecutive RegWrite pulses, in order, values matching; retired_count=4.
- Flush in WAIT_LOAD with LoadValid=1 in the same cycle -> no RegWrite, state IDLE, retired_count unchanged.
- With WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16: load with no LoadValid -> load_error pulses after 16 WAIT_LOAD cycles; no write; in_ready returns to 1. Repeat with async reset mid-wait -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/wb_commit_stage_if.sv
// MEM -> WB retirement handshake: instruction capture fields plus the load-data return path.
interface wb_commit_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic [4:0]  WriteRegister_in;
  logic [31:0] ALUResult_in;
  logic [31:0] LoadData;
  logic        LoadValid;

  modport master (
    output in_valid, RegWrite_in, MemtoReg_in, WriteRegister_in, ALUResult_in,
    output LoadData, LoadValid,
    input  in_ready
  );

  modport slave (
    input  in_valid, RegWrite_in, MemtoReg_in, WriteRegister_in, ALUResult_in,
    input  LoadData, LoadValid,
    output in_ready
  );
endinterface

// File: rtl/wb_commit_stage.sv
// MEM/WB pipeline register and write-back select; stalls upstream while a load is outstanding.
// Optional load watchdog enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_commit_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_commit_stage_if.slave     bus,
  input  logic                 flush,
  output logic [4:0]           WriteRegister,
  output logic [31:0]          WriteData,
  output logic                 RegWrite,
  output logic                 load_stall,
  output logic                 load_error,
  output logic [CNT_W-1:0]     retired_count
);

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_t;

  state_t state;
  state_t nextState;

  logic       accept;
  logic       aluCommit;
  logic       loadStart;
  logic       loadDone;
  logic       timeout;
  logic [4:0] pendReg;
  logic       pendWr;

  // flush squashes anything arriving in the same cycle, including load data
  assign accept    = bus.in_valid && (state == IDLE) && !flush;
  assign aluCommit = accept && !bus.MemtoReg_in;
  assign loadStart = accept && bus.MemtoReg_in;
  assign loadDone  = (state == WAIT_LOAD) && bus.LoadValid && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (loadStart) nextState = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (flush || bus.LoadValid || timeout) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
    load_stall   = (state == WAIT_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendReg <= '0;
      pendWr  <= 1'b0;
    end else if (loadStart) begin
      pendReg <= bus.WriteRegister_in;
      pendWr  <= bus.RegWrite_in;
    end
  end

  // Address/data update on every commit; RegWrite masks writes to $0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      retired_count <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (aluCommit) begin
        WriteRegister <= bus.WriteRegister_in;
        WriteData     <= bus.ALUResult_in;
        RegWrite      <= bus.RegWrite_in && (bus.WriteRegister_in != 5'd0);
        retired_count <= retired_count + CNT_W'(1);
      end else if (loadDone) begin
        WriteRegister <= pendReg;
        WriteData     <= bus.LoadData;
        RegWrite      <= pendWr && (pendReg != 5'd0);
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] waitCnt;

  // Expiry is the TIMEOUT_CYCLES-th empty wait cycle; load data arriving then still wins
  assign timeout = (state == WAIT_LOAD) && !flush && !bus.LoadValid &&
                   (waitCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (loadStart) begin
      waitCnt <= '0;
    end else if ((state == WAIT_LOAD) && !bus.LoadValid) begin
      waitCnt <= waitCnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_error <= 1'b0;
    end else begin
      load_error <= timeout;
    end
  end
`else
  logic unusedTimeoutCfg;

  assign timeout          = 1'b0;
  assign load_error       = 1'b0;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed steps then random traffic checked against a transaction-level model.
module tb_wb_commit_stage;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        load_stall;
  logic        load_error;
  logic [31:0] retired_count;

  int total = 0;
  int bad   = 0;

  // reference model: one outstanding load record plus the expected register-file view
  bit          mBusy;
  logic [4:0]  mPendReg;
  logic        mPendWr;
  int          mWait;
  logic [4:0]  eWR;
  logic [31:0] eWD;
  logic        eRW;
  logic        eErr;
  logic [31:0] eCnt;

  wb_commit_stage_if wbIf ();

  wb_commit_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (wbIf.slave),
    .flush         (flush),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .load_stall    (load_stall),
    .load_error    (load_error),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mPendReg = '0; mPendWr = 0; mWait = 0;
    eWR = '0; eWD = '0; eRW = 0; eErr = 0; eCnt = '0;
  endtask

  task automatic checkOutputs();
    check("in_ready", 32'(wbIf.in_ready), 32'(!mBusy));
    check("load_stall", 32'(load_stall), 32'(mBusy));
    check("RegWrite", 32'(RegWrite), 32'(eRW));
    check("WriteRegister", 32'(WriteRegister), 32'(eWR));
    check("WriteData", WriteData, eWD);
    check("retired_count", retired_count, eCnt);
    check("load_error", 32'(load_error), 32'(eErr));
  endtask

  task automatic drive(input logic v, input logic wr, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic lv, input logic [31:0] ld, input logic fl);
    wbIf.in_valid = v; wbIf.RegWrite_in = wr; wbIf.MemtoReg_in = m2r;
    wbIf.WriteRegister_in = rd; wbIf.ALUResult_in = alu;
    wbIf.LoadValid = lv; wbIf.LoadData = ld; flush = fl;
  endtask

  // one clock: predict from the current request, advance, then compare after the edge
  task automatic cycle();
    bit          doCommit;
    logic [4:0]  cReg;
    logic [31:0] cData;
    logic        cWr;
    check("in_ready_pre", 32'(wbIf.in_ready), 32'(!mBusy));
    check("load_stall_pre", 32'(load_stall), 32'(mBusy));
    doCommit = 0; cReg = '0; cData = '0; cWr = 0; eErr = 0;
    if (flush) begin
      mBusy = 0;
    end else if (!mBusy) begin
      if (wbIf.in_valid) begin
        if (wbIf.MemtoReg_in) begin
          mBusy = 1; mPendReg = wbIf.WriteRegister_in; mPendWr = wbIf.RegWrite_in; mWait = 0;
        end else begin
          doCommit = 1; cReg = wbIf.WriteRegister_in; cData = wbIf.ALUResult_in; cWr = wbIf.RegWrite_in;
        end
      end
    end else if (wbIf.LoadValid) begin
      doCommit = 1; cReg = mPendReg; cData = wbIf.LoadData; cWr = mPendWr; mBusy = 0;
    end else begin
      mWait++;
`ifdef WB_LOAD_TIMEOUT_EN
      if (mWait == TO) begin
        eErr = 1; mBusy = 0;
      end
`endif
    end
    eRW = doCommit && cWr && (cReg != 5'd0);
    if (doCommit) begin
      eWR = cReg; eWD = cData; eCnt = eCnt + 32'd1;
    end
    @(posedge clk);
    #1;
    checkOutputs();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, '0, '0, 0, '0, 0);
      cycle();
    end
  endtask

  task automatic syncReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, '0, '0, 0, '0, 0);
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutputs();
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write to r5
    drive(1, 1, 0, 5'd5, 32'h0000_00AA, 0, '0, 0); cycle();
    check("alu_r5_count", retired_count, 32'd1);
    check("alu_r5_data", WriteData, 32'h0000_00AA);
    // write to $0 is suppressed but still retires
    drive(1, 1, 0, 5'd0, 32'h0000_1234, 0, '0, 0); cycle();
    check("r0_nowrite", 32'(RegWrite), 32'd0);

    // load to r9; LoadValid in the capture cycle must be ignored
    drive(1, 1, 1, 5'd9, 32'h5555_5555, 1, 32'h1111_1111, 0); cycle();
    check("load_stall_wait", 32'(load_stall), 32'd1);
    idleCycles(2);
    drive(0, 0, 0, '0, '0, 1, 32'hDEAD_BEEF, 0); cycle();
    check("load_commit_data", WriteData, 32'hDEAD_BEEF);
    check("load_commit_ready", 32'(wbIf.in_ready), 32'd1);

    // minimum-latency load followed by back-to-back ALU ops
    syncReset();
    drive(1, 1, 1, 5'd7, '0, 0, '0, 0); cycle();
    drive(0, 0, 0, '0, '0, 1, 32'hCAFE_0007, 0); cycle();
    syncReset();
    for (int r = 1; r <= 4; r++) begin
      drive(1, 1, 0, 5'(r), 32'h100 + 32'(r), 0, '0, 0); cycle();
      check("b2b_pulse", 32'(RegWrite), 32'd1);
    end
    check("b2b_count", retired_count, 32'd4);

    // flush while waiting, with LoadValid in the same cycle
    drive(1, 1, 1, 5'd3, '0, 0, '0, 0); cycle();
    drive(0, 0, 0, '0, '0, 1, 32'hBAD0_BAD0, 1); cycle();
    check("flush_count", retired_count, 32'd4);
    // flush in IDLE discards an ALU transfer
    drive(1, 1, 0, 5'd6, 32'h66, 0, '0, 1); cycle();

    // long wait without data
    drive(1, 1, 1, 5'd12, '0, 0, '0, 0); cycle();
    idleCycles(TO + 2);
`ifdef WB_LOAD_TIMEOUT_EN
    // LoadValid in the expiry cycle wins over the timeout
    drive(1, 1, 1, 5'd13, '0, 0, '0, 0); cycle();
    idleCycles(TO - 1);
    drive(0, 0, 0, '0, '0, 1, 32'h1357_9BDF, 0); cycle();
`else
    drive(0, 0, 0, '0, '0, 1, 32'h2468_ACE0, 0); cycle();
`endif

    // async reset in the middle of a wait
    drive(1, 1, 1, 5'd14, '0, 0, '0, 0); cycle();
    idleCycles(3);
    #2;
    syncReset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0), $urandom,
            ($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
